// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the issue-side hazard logic.
//   REG_W    : register-index width
//   ZERO_REG : architectural zero register (never creates a dependency)
//   slot_t   : shadow copy of one pipeline slot {valid, dest, wb_en, mem_r_en}
//   BUBBLE   : empty slot (all zero)
//   slot_match() : RAW test of one source register against one slot
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int REG_W = 5;

   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic             wb_en;
      logic             mem_r_en;
   } slot_t;

   localparam slot_t BUBBLE = '0;

   // A slot produces a value for src only if it is a real instruction that
   // writes the register file, targets src, and src is not the zero register.
   function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] src);
      return s.valid & s.wb_en & (s.dest == src) & (src != ZERO_REG);
   endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// -----------------------------------------------------------------------------
// hazard_slot_reg
// One shadow pipeline slot register.
//   clk  : clock, updates on posedge
//   rst  : synchronous active-high reset, loads BUBBLE
//   hold : pipeline freeze; q keeps its value
//   d    : next slot contents
//   q    : current slot contents
// -----------------------------------------------------------------------------
module hazard_slot_reg
   import cpu_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  hold,
   input  slot_t d,
   output slot_t q
);

   slot_t r_slot;

   // NOTE: sequential state uses non-blocking assignments so every slot
   // samples its neighbour's pre-edge value and the chain shifts by one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot <= BUBBLE;
      end else if (!hold) begin
         r_slot <= d;
      end
   end

   assign q = r_slot;

endmodule

// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
// Decides whether the ID-stage instruction may advance into EXE, keeps a shadow
// of the EXE/MEM/WB destination fields for the forwarding unit, and counts
// stall cycles.
//   clk, rst            : clock, synchronous active-high reset
//   src1_ID, src2_ID    : source registers of the ID instruction
//   is_two_source       : src2_ID is actually read
//   valid_ID            : ID slot holds a real instruction
//   dest_ID, WB_EN_ID,
//   MEM_R_EN_ID         : fields copied into EXE when the instruction issues
//   forward_en          : 1 = only load-use stalls, 0 = stall on any EXE/MEM RAW
//   freeze              : memory wait, whole pipeline holds
//   flush               : squash the ID instruction (EXE gets a bubble)
//   hazard              : stall IF/ID this cycle (combinational)
//   dest_MEM, dest_WB   : registered destinations of MEM and WB slots
//   WB_EN_MEM, WB_EN_WB : registered write enables, 0 for invalid slots
//   MEM_R_EN_EXE        : EXE slot holds a valid load
//   stall_count         : cycles with hazard=1 and freeze=0, saturating
// -----------------------------------------------------------------------------
module hazard_detection_unit #(
   parameter int REG_W = cpu_pkg::REG_W,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] src1_ID,
   input  logic [REG_W-1:0] src2_ID,
   input  logic             is_two_source,
   input  logic             valid_ID,
   input  logic [REG_W-1:0] dest_ID,
   input  logic             WB_EN_ID,
   input  logic             MEM_R_EN_ID,
   input  logic             forward_en,
   input  logic             freeze,
   input  logic             flush,
   output logic             hazard,
   output logic [REG_W-1:0] dest_MEM,
   output logic [REG_W-1:0] dest_WB,
   output logic             WB_EN_MEM,
   output logic             WB_EN_WB,
   output logic             MEM_R_EN_EXE,
   output logic [CNT_W-1:0] stall_count
);

   import cpu_pkg::slot_t;
   import cpu_pkg::BUBBLE;
   import cpu_pkg::slot_match;

   slot_t            w_exe_d;
   slot_t            w_exe_q;
   slot_t            w_mem_q;
   slot_t            w_wb_q;
   logic             w_hit_exe;
   logic             w_hit_mem;
   logic             w_hazard;
   logic [CNT_W-1:0] r_stall_count;

   // ---------------------------------------------------------------- match --
   assign w_hit_exe = slot_match(w_exe_q, src1_ID)
                    | (is_two_source & slot_match(w_exe_q, src2_ID));
   assign w_hit_mem = slot_match(w_mem_q, src1_ID)
                    | (is_two_source & slot_match(w_mem_q, src2_ID));

   // With forwarding only a load still in EXE cannot be bypassed; without it
   // any producer in EXE or MEM blocks. WB writes before ID reads, so never.
   assign w_hazard = valid_ID & (forward_en ? (w_hit_exe & w_exe_q.mem_r_en)
                                            : (w_hit_exe | w_hit_mem));

   assign hazard = w_hazard;

   // ------------------------------------------------------------ EXE input --
   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_exe_d = BUBBLE;
      if (valid_ID && !flush && !w_hazard) begin
         w_exe_d.valid    = 1'b1;
         w_exe_d.dest     = dest_ID;
         w_exe_d.wb_en    = WB_EN_ID;
         w_exe_d.mem_r_en = MEM_R_EN_ID;
      end
   end

   // ---------------------------------------------------------------- slots --
   hazard_slot_reg u_exe (
      .clk  (clk),
      .rst  (rst),
      .hold (freeze),
      .d    (w_exe_d),
      .q    (w_exe_q)
   );

   hazard_slot_reg u_mem (
      .clk  (clk),
      .rst  (rst),
      .hold (freeze),
      .d    (w_exe_q),
      .q    (w_mem_q)
   );

   hazard_slot_reg u_wb (
      .clk  (clk),
      .rst  (rst),
      .hold (freeze),
      .d    (w_mem_q),
      .q    (w_wb_q)
   );

   // -------------------------------------------------------- stall counter --
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= '0;
      end else if (w_hazard && !freeze && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   // -------------------------------------------------------------- outputs --
   assign dest_MEM     = w_mem_q.dest;
   assign dest_WB      = w_wb_q.dest;
   assign WB_EN_MEM    = w_mem_q.valid & w_mem_q.wb_en;
   assign WB_EN_WB     = w_wb_q.valid & w_wb_q.wb_en;
   assign MEM_R_EN_EXE = w_exe_q.valid & w_exe_q.mem_r_en;
   assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detection_unit
// Directed vectors for hazard_detection_unit. A second instance with a 4-bit
// counter shares the stimulus and is used for the saturation check.
// -----------------------------------------------------------------------------
module tb_hazard_detection_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] src1_ID, src2_ID, dest_ID;
   logic       is_two_source, valid_ID, WB_EN_ID, MEM_R_EN_ID;
   logic       forward_en, freeze, flush;

   logic        hazard;
   logic [4:0]  dest_MEM, dest_WB;
   logic        WB_EN_MEM, WB_EN_WB, MEM_R_EN_EXE;
   logic [31:0] stall_count;

   logic        s_hazard;
   logic [4:0]  s_dest_MEM, s_dest_WB;
   logic        s_WB_EN_MEM, s_WB_EN_WB, s_MEM_R_EN_EXE;
   logic [3:0]  s_stall_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hazard_detection_unit u_dut (
      .clk           (clk),
      .rst           (rst),
      .src1_ID       (src1_ID),
      .src2_ID       (src2_ID),
      .is_two_source (is_two_source),
      .valid_ID      (valid_ID),
      .dest_ID       (dest_ID),
      .WB_EN_ID      (WB_EN_ID),
      .MEM_R_EN_ID   (MEM_R_EN_ID),
      .forward_en    (forward_en),
      .freeze        (freeze),
      .flush         (flush),
      .hazard        (hazard),
      .dest_MEM      (dest_MEM),
      .dest_WB       (dest_WB),
      .WB_EN_MEM     (WB_EN_MEM),
      .WB_EN_WB      (WB_EN_WB),
      .MEM_R_EN_EXE  (MEM_R_EN_EXE),
      .stall_count   (stall_count)
   );

   hazard_detection_unit #(.CNT_W(4)) u_sat (
      .clk           (clk),
      .rst           (rst),
      .src1_ID       (src1_ID),
      .src2_ID       (src2_ID),
      .is_two_source (is_two_source),
      .valid_ID      (valid_ID),
      .dest_ID       (dest_ID),
      .WB_EN_ID      (WB_EN_ID),
      .MEM_R_EN_ID   (MEM_R_EN_ID),
      .forward_en    (forward_en),
      .freeze        (freeze),
      .flush         (flush),
      .hazard        (s_hazard),
      .dest_MEM      (s_dest_MEM),
      .dest_WB       (s_dest_WB),
      .WB_EN_MEM     (s_WB_EN_MEM),
      .WB_EN_WB      (s_WB_EN_WB),
      .MEM_R_EN_EXE  (s_MEM_R_EN_EXE),
      .stall_count   (s_stall_count)
   );

   typedef struct {
      logic        v;
      logic [4:0]  s1, s2;
      logic        two;
      logic [4:0]  d;
      logic        we, mr, fwd;
      logic        hz;
      logic [4:0]  dm;
      logic        wem;
      logic [4:0]  dwb;
      logic        wewb, mre;
      logic [31:0] cnt;
   } vec_t;

   function automatic vec_t mk(
      input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic two,
      input logic [4:0] d, input logic we, input logic mr, input logic fwd,
      input logic hz, input logic [4:0] dm, input logic wem, input logic [4:0] dwb,
      input logic wewb, input logic mre, input logic [31:0] cnt);
      vec_t r;
      r.v = v; r.s1 = s1; r.s2 = s2; r.two = two; r.d = d; r.we = we; r.mr = mr;
      r.fwd = fwd; r.hz = hz; r.dm = dm; r.wem = wem; r.dwb = dwb; r.wewb = wewb;
      r.mre = mre; r.cnt = cnt;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic two, input logic [4:0] d, input logic we,
                        input logic mr, input logic fwd, input logic frz, input logic fl);
      valid_ID = v; src1_ID = s1; src2_ID = s2; is_two_source = two;
      dest_ID = d; WB_EN_ID = we; MEM_R_EN_ID = mr; forward_en = fwd;
      freeze = frz; flush = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[19];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Load-use with forwarding, then back-to-back RAW without forwarding,
      // then zero-register and is_two_source gating.
      vecs[0]  = mk(1, 1, 0, 0, 3, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 3, 2, 1, 4, 1, 0, 1,  1, 0, 0, 0, 0, 1, 0);
      vecs[2]  = mk(1, 3, 2, 1, 4, 1, 0, 1,  0, 3, 1, 0, 0, 0, 1);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3, 1, 0, 1);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 4, 1, 0, 0, 0, 1);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 4, 1, 0, 1);
      vecs[6]  = mk(1, 1, 2, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
      vecs[7]  = mk(1, 7, 5, 1, 6, 1, 0, 0,  1, 0, 0, 0, 0, 0, 1);
      vecs[8]  = mk(1, 7, 5, 1, 6, 1, 0, 0,  1, 5, 1, 0, 0, 0, 2);
      vecs[9]  = mk(1, 7, 5, 1, 6, 1, 0, 0,  0, 0, 0, 5, 1, 0, 3);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 6, 1, 0, 0, 0, 3);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6, 1, 0, 3);
      vecs[13] = mk(1, 1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 3);
      vecs[14] = mk(1, 0, 0, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0, 0, 3);
      vecs[15] = mk(1, 9, 7, 0, 8, 1, 0, 0,  0, 0, 1, 0, 0, 0, 3);
      vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 7, 1, 0, 1, 0, 3);
      vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 8, 1, 7, 1, 0, 3);
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 8, 1, 0, 3);

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // ------------------------------------------------------ table vectors --
      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].v, vecs[i].s1, vecs[i].s2, vecs[i].two, vecs[i].d,
               vecs[i].we, vecs[i].mr, vecs[i].fwd, 0, 0);
         check($sformatf("v%0d hazard", i),       32'(hazard),       32'(vecs[i].hz));
         check($sformatf("v%0d dest_MEM", i),     32'(dest_MEM),     32'(vecs[i].dm));
         check($sformatf("v%0d WB_EN_MEM", i),    32'(WB_EN_MEM),    32'(vecs[i].wem));
         check($sformatf("v%0d dest_WB", i),      32'(dest_WB),      32'(vecs[i].dwb));
         check($sformatf("v%0d WB_EN_WB", i),     32'(WB_EN_WB),     32'(vecs[i].wewb));
         check($sformatf("v%0d MEM_R_EN_EXE", i), 32'(MEM_R_EN_EXE), 32'(vecs[i].mre));
         check($sformatf("v%0d stall_count", i),  stall_count,       vecs[i].cnt);
         tick();
      end

      // --------------------------------------------- freeze during load-use --
      drive(1, 1, 0, 0, 3, 1, 1, 1, 0, 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1, 3, 2, 1, 4, 1, 0, 1, 1, 0);
         check($sformatf("frz%0d hazard", k),       32'(hazard),       32'd1);
         check($sformatf("frz%0d MEM_R_EN_EXE", k), 32'(MEM_R_EN_EXE), 32'd1);
         check($sformatf("frz%0d dest_MEM", k),     32'(dest_MEM),     32'd0);
         check($sformatf("frz%0d stall_count", k),  stall_count,       32'd3);
         tick();
      end
      drive(1, 3, 2, 1, 4, 1, 0, 1, 0, 0);
      check("unfrz hazard",       32'(hazard),       32'd1);
      check("unfrz MEM_R_EN_EXE", 32'(MEM_R_EN_EXE), 32'd1);
      check("unfrz stall_count",  stall_count,       32'd3);
      tick();
      check("post-frz hazard",       32'(hazard),       32'd0);
      check("post-frz dest_MEM",     32'(dest_MEM),     32'd3);
      check("post-frz MEM_R_EN_EXE", 32'(MEM_R_EN_EXE), 32'd0);
      check("post-frz stall_count",  stall_count,       32'd4);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (3) tick();

      // ---------------------------------------------------- flush over hazard --
      drive(1, 1, 0, 0, 3, 1, 1, 1, 0, 0);
      tick();
      drive(1, 3, 0, 0, 4, 1, 0, 1, 0, 1);
      check("flush hazard", 32'(hazard), 32'd1);
      tick();
      drive(1, 1, 0, 0, 9, 1, 0, 1, 0, 0);
      check("flush next hazard",      32'(hazard),       32'd0);
      check("flush EXE bubble",       32'(MEM_R_EN_EXE), 32'd0);
      check("flush stall_count",      stall_count,       32'd5);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("flush bubble in MEM",    32'(WB_EN_MEM),    32'd0);
      tick();
      check("flush issue dest_MEM",   32'(dest_MEM),     32'd9);
      check("flush issue WB_EN_MEM",  32'(WB_EN_MEM),    32'd1);
      repeat (3) tick();

      // ------------------------------------------------------ mid-run reset --
      drive(1, 1, 2, 1, 4, 1, 0, 1, 0, 0);
      tick();
      drive(1, 1, 0, 0, 3, 1, 1, 1, 0, 0);
      tick();
      drive(1, 3, 0, 0, 5, 1, 0, 1, 0, 0);
      check("pre-rst hazard",       32'(hazard),       32'd1);
      check("pre-rst MEM_R_EN_EXE", 32'(MEM_R_EN_EXE), 32'd1);
      check("pre-rst dest_MEM",     32'(dest_MEM),     32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rst hazard",       32'(hazard),        32'd0);
      check("rst MEM_R_EN_EXE", 32'(MEM_R_EN_EXE),  32'd0);
      check("rst dest_MEM",     32'(dest_MEM),      32'd0);
      check("rst WB_EN_MEM",    32'(WB_EN_MEM),     32'd0);
      check("rst dest_WB",      32'(dest_WB),       32'd0);
      check("rst WB_EN_WB",     32'(WB_EN_WB),      32'd0);
      check("rst stall_count",  stall_count,        32'd0);
      check("rst sat count",    32'(s_stall_count), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();

      // ------------------------------------- saturation (2 stalls per pass) --
      for (int it = 0; it < 10; it++) begin
         int exp_main;
         int exp_sat;
         drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
         check($sformatf("sat%0d producer hazard", it), 32'(hazard), 32'd0);
         tick();
         drive(1, 1, 0, 0, 2, 1, 0, 0, 0, 0);
         check($sformatf("sat%0d stall1", it), 32'(hazard), 32'd1);
         tick();
         check($sformatf("sat%0d stall2", it), 32'(hazard), 32'd1);
         tick();
         check($sformatf("sat%0d issue", it), 32'(hazard), 32'd0);
         tick();
         exp_main = 2 * (it + 1);
         exp_sat  = (exp_main > 15) ? 15 : exp_main;
         check($sformatf("sat%0d main count", it), stall_count,        32'(exp_main));
         check($sformatf("sat%0d 4b count", it),   32'(s_stall_count), 32'(exp_sat));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
